iohub_uart_tx_framer: RTL and testbench

- Transmit-side counterpart of the IO hub receive framer.
- Drains 16-bit words from the hub's outbound FIFO and sends each word as a framed UART byte sequence: header 0x80, then the high byte, then the low byte.
- Also sends single-byte control tokens: status 0x40 and ready 0x20.
- Sits between the outbound FIFO read port and the UART transmitter's transmit/tx_byte/is_transmitting interface, in the same clock domain as the UART.

---
 rtl/iohub_uart_tx_framer.sv | 190 +++++++++++++++++++
 tb/tb_iohub_uart_tx_framer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iohub_uart_tx_framer.sv
// UART transmit framer for the IO hub: sends FIFO words as HDR/hi/lo frames plus status/ready tokens.
// Define IOHUB_TX_CSUM_EN to append an XOR checksum byte to every data frame.
module iohub_uart_tx_framer #(
  parameter logic [7:0] HDR_BYTE      = 8'h80,
  parameter logic [7:0] STATUS_BYTE   = 8'h40,
  parameter logic [7:0] READY_BYTE    = 8'h20,
  parameter int         START_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fifo_empty_i,
  input  logic [15:0] fifo_dout_i,
  output logic        fifo_rd_en_o,
  input  logic        send_status_i,
  input  logic        send_ready_i,
  input  logic        uart_busy_i,
  output logic        uart_transmit_o,
  output logic [7:0]  uart_tx_byte_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        tx_err_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH      = 3'd1;
  localparam logic [2:0] ST_LATCH      = 3'd2;
  localparam logic [2:0] ST_SEND       = 3'd3;
  localparam logic [2:0] ST_WAIT_START = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd5;

`ifdef IOHUB_TX_CSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif
  localparam logic [7:0] TIMEOUT_LAST = 8'(START_TIMEOUT - 1);

  logic [2:0]  state_reg, state_next;
  logic        status_pend_reg, status_pend_next;
  logic        ready_pend_reg, ready_pend_next;
  logic        is_token_reg, is_token_next;
  logic        tok_status_reg, tok_status_next;
  logic [15:0] word_reg, word_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [7:0]  tx_byte_reg, tx_byte_next;
  logic [7:0]  timeout_reg, timeout_next;
  logic        frame_done_reg, frame_done_next;
  logic        tx_err_reg, tx_err_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic        status_clr, ready_clr;
  logic [1:0]  byte_idx_inc;

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] w);
    logic [7:0] b;
    case (idx)
      2'd0:    b = HDR_BYTE;
      2'd1:    b = w[15:8];
      2'd2:    b = w[7:0];
`ifdef IOHUB_TX_CSUM_EN
      default: b = HDR_BYTE ^ w[15:8] ^ w[7:0];
`else
      default: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

  assign byte_idx_inc = byte_idx_reg + 2'd1;

  always_comb begin
    state_next      = state_reg;
    is_token_next   = is_token_reg;
    tok_status_next = tok_status_reg;
    word_next       = word_reg;
    byte_idx_next   = byte_idx_reg;
    tx_byte_next    = tx_byte_reg;
    timeout_next    = timeout_reg;
    frame_cnt_next  = frame_cnt_reg;
    frame_done_next = 1'b0;
    tx_err_next     = 1'b0;
    status_clr      = 1'b0;
    ready_clr       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!uart_busy_i) begin
          if (status_pend_reg) begin
            tx_byte_next    = STATUS_BYTE;
            is_token_next   = 1'b1;
            tok_status_next = 1'b1;
            state_next      = ST_SEND;
          end else if (ready_pend_reg) begin
            tx_byte_next    = READY_BYTE;
            is_token_next   = 1'b1;
            tok_status_next = 1'b0;
            state_next      = ST_SEND;
          end else if (!fifo_empty_i) begin
            is_token_next   = 1'b0;
            state_next      = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: begin
        word_next     = fifo_dout_i;
        byte_idx_next = 2'd0;
        tx_byte_next  = HDR_BYTE;
        state_next    = ST_SEND;
      end
      ST_SEND: begin
        timeout_next = 8'd0;
        state_next   = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (uart_busy_i) begin
          state_next = ST_WAIT_DONE;
        end else if (timeout_reg == TIMEOUT_LAST) begin
          // Abort leaves the pending flag untouched so the token is retried.
          tx_err_next = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          timeout_next = timeout_reg + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy_i) begin
          if (!is_token_reg && byte_idx_reg != LAST_IDX) begin
            byte_idx_next = byte_idx_inc;
            tx_byte_next  = frame_byte(byte_idx_inc, word_reg);
            state_next    = ST_SEND;
          end else if (!is_token_reg) begin
            frame_done_next = 1'b1;
            frame_cnt_next  = frame_cnt_reg + 16'd1;
            state_next      = ST_IDLE;
          end else begin
            status_clr = tok_status_reg;
            ready_clr  = !tok_status_reg;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A new request in the same cycle as a clear keeps the flag set.
    status_pend_next = send_status_i | (status_pend_reg & ~status_clr);
    ready_pend_next  = send_ready_i  | (ready_pend_reg  & ~ready_clr);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg       <= ST_IDLE;
      status_pend_reg <= 1'b0;
      ready_pend_reg  <= 1'b0;
      is_token_reg    <= 1'b0;
      tok_status_reg  <= 1'b0;
      word_reg        <= 16'd0;
      byte_idx_reg    <= 2'd0;
      tx_byte_reg     <= 8'd0;
      timeout_reg     <= 8'd0;
      frame_done_reg  <= 1'b0;
      tx_err_reg      <= 1'b0;
      frame_cnt_reg   <= 16'd0;
    end else begin
      state_reg       <= state_next;
      status_pend_reg <= status_pend_next;
      ready_pend_reg  <= ready_pend_next;
      is_token_reg    <= is_token_next;
      tok_status_reg  <= tok_status_next;
      word_reg        <= word_next;
      byte_idx_reg    <= byte_idx_next;
      tx_byte_reg     <= tx_byte_next;
      timeout_reg     <= timeout_next;
      frame_done_reg  <= frame_done_next;
      tx_err_reg      <= tx_err_next;
      frame_cnt_reg   <= frame_cnt_next;
    end
  end

  // Read strobe lives in FETCH so data lands exactly when LATCH samples it.
  assign fifo_rd_en_o    = (state_reg == ST_FETCH);
  assign uart_transmit_o = (state_reg == ST_SEND);
  assign uart_tx_byte_o  = tx_byte_reg;
  assign busy_o          = (state_reg != ST_IDLE);
  assign frame_done_o    = frame_done_reg;
  assign tx_err_o        = tx_err_reg;
  assign frame_cnt_o     = frame_cnt_reg;

endmodule

// File: tb/tb_iohub_uart_tx_framer.sv
// Scoreboard bench for iohub_uart_tx_framer: directed frames/tokens, UART and FIFO models.
module tb_iohub_uart_tx_framer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout = 16'h0000;
  logic        fifo_rd_en_o;
  logic        send_status = 1'b0;
  logic        send_ready = 1'b0;
  logic        uart_busy;
  logic        uart_transmit_o;
  logic [7:0]  uart_tx_byte_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        tx_err_o;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int strobe_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] fifo_q[$];
  int  busy_cnt = 0;
  bit  uart_dead = 1'b0;

  iohub_uart_tx_framer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fifo_empty_i   (fifo_empty),
    .fifo_dout_i    (fifo_dout),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .send_status_i  (send_status),
    .send_ready_i   (send_ready),
    .uart_busy_i    (uart_busy),
    .uart_transmit_o(uart_transmit_o),
    .uart_tx_byte_o (uart_tx_byte_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .tx_err_o       (tx_err_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // UART model: busy for 10 cycles after each strobe, unless configured dead.
  assign uart_busy = (busy_cnt != 0);
  always @(posedge clk_i) begin
    if (uart_transmit_o && !uart_dead && busy_cnt == 0) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Standard (non-FWFT) FIFO model.
  assign fifo_empty = (fifo_q.size() == 0);
  always @(posedge clk_i) begin
    if (fifo_rd_en_o && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic push_frame(input logic [15:0] w);
    logic [7:0] hi, lo;
    hi = w[15:8];
    lo = w[7:0];
    exp_q.push_back(8'h80);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
`ifdef IOHUB_TX_CSUM_EN
    exp_q.push_back(8'h80 ^ hi ^ lo);
`endif
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy_o && !uart_busy) && n < max_cyc) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending=%0d busy=%0b", name, exp_q.size(), busy_o);
    end
    repeat (3) @(negedge clk_i);
  endtask

  // Monitor: pops the scoreboard on every transmit strobe and tallies side pulses.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (uart_transmit_o) begin
        logic [7:0] e;
        last_strobe_cyc = cyc;
        strobe_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe got=%02h expected=none", uart_tx_byte_o);
        end else begin
          e = exp_q.pop_front();
          if (uart_tx_byte_o !== e) begin
            errors++;
            $display("FAIL tx_byte got=%02h expected=%02h", uart_tx_byte_o, e);
          end else begin
            $display("tx   byte=%02h cyc=%0d", uart_tx_byte_o, cyc);
          end
        end
      end
      if (fifo_rd_en_o) begin
        rd_cnt++;
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL rd_when_empty got=1 expected=0");
        end
      end
      if (frame_done_o) done_cnt++;
      if (tx_err_o) begin
        err_cnt++;
        check("err_latency", 32'(cyc - last_strobe_cyc), 32'd17);
        check("busy_at_err", {31'd0, busy_o}, 32'd0);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk_i);
    check("rst_transmit", {31'd0, uart_transmit_o}, 0);
    check("rst_rd_en", {31'd0, fifo_rd_en_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_frame_cnt", {16'd0, frame_cnt_o}, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Single frame 0xA55A.
    push_frame(16'hA55A);
    fifo_q.push_back(16'hA55A);
    wait_drain("frame_a55a", 200);
    check("a55a_rd_cnt", rd_cnt, 1);
    check("a55a_done_cnt", done_cnt, 1);
    check("a55a_frame_cnt", {16'd0, frame_cnt_o}, 1);

    // Both tokens together, then a word: tokens first in priority order.
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h20);
    push_frame(16'hBEEF);
    send_status = 1'b1;
    send_ready  = 1'b1;
    @(negedge clk_i);
    send_status = 1'b0;
    send_ready  = 1'b0;
    fifo_q.push_back(16'hBEEF);
    wait_drain("tokens_then_frame", 300);
    check("beef_frame_cnt", {16'd0, frame_cnt_o}, 2);

    // Ready requested mid-frame goes out after the frame.
    push_frame(16'h1234);
    exp_q.push_back(8'h20);
    fifo_q.push_back(16'h1234);
    n = 0;
    while (exp_q.size() > 3 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    send_ready = 1'b1;
    @(negedge clk_i);
    send_ready = 1'b0;
    wait_drain("ready_mid_frame", 300);
    check("1234_frame_cnt", {16'd0, frame_cnt_o}, 3);
    check("1234_done_cnt", done_cnt, 3);

    // Dead UART: start timeout, then the token is retried once the UART recovers.
    uart_dead = 1'b1;
    exp_q.push_back(8'h40);
    send_status = 1'b1;
    @(negedge clk_i);
    send_status = 1'b0;
    n = 0;
    while (!tx_err_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("timeout_seen", {31'd0, tx_err_o}, 1);
    uart_dead = 1'b0;
    exp_q.push_back(8'h40);
    wait_drain("status_retry", 200);
    check("err_cnt", err_cnt, 1);
    check("retry_frame_cnt", {16'd0, frame_cnt_o}, 3);

`ifdef IOHUB_TX_CSUM_EN
    push_frame(16'h0F0F);
    fifo_q.push_back(16'h0F0F);
    wait_drain("csum_frame", 300);
    check("csum_frame_cnt", {16'd0, frame_cnt_o}, 4);
`endif

    // Reset while waiting for the high byte to finish.
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h77);
    fifo_q.push_back(16'h7777);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    check("pre_rst_busy", {31'd0, busy_o}, 1);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    check("mid_rst_transmit", {31'd0, uart_transmit_o}, 0);
    check("mid_rst_tx_byte", {24'd0, uart_tx_byte_o}, 0);
    check("mid_rst_busy", {31'd0, busy_o}, 0);
    check("mid_rst_done", {31'd0, frame_done_o}, 0);
    check("mid_rst_err", {31'd0, tx_err_o}, 0);
    check("mid_rst_frame_cnt", {16'd0, frame_cnt_o}, 0);
    n = strobe_cnt;
    repeat (40) @(negedge clk_i);
    check("post_rst_strobes", strobe_cnt - n, 0);
    check("post_rst_busy", {31'd0, busy_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
